// File: rtl/rf_wb_pkg.sv
// Purpose: shared types and constants for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rf_wb_pkg;

    // Register index width and the hard-wired zero register
    localparam int REG_IDX_W = 4;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    // Requester index encoding, also used as the grant selector
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_e;

    // Holding-buffer entry control fields. The data word is held alongside
    // the entry because its width is a per-instance parameter.
    // age = 1 marks the younger of two full buffers.
    typedef struct packed {
        logic                 full;
        logic                 age;
        logic [REG_IDX_W-1:0] dest;
    } wb_entry_t;

    // Writes to the zero register are dropped at acceptance
    function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// Purpose: single-entry writeback holding buffer (full/dest/data/age).
// Latency: loaded value visible the cycle after the load edge.
// Backpressure: none internally; the owner decides when to load or clear.
// Ports: clk, rst (async active-high), ld/ld_dest/ld_data load strobe and
//        payload, clr drains the entry, age_nxt is the age to hold next,
//        entry/data expose the registered contents.
module wb_hold_buf
    import rf_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld,
    input  logic                 clr,
    input  logic [REG_IDX_W-1:0] ld_dest,
    input  logic [XLEN-1:0]      ld_data,
    input  logic                 age_nxt,
    output wb_entry_t            entry,
    output logic [XLEN-1:0]      data
);

    // A load wins over a clear so a drained entry can be refilled at the
    // same edge; the age is refreshed every cycle by the owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry <= '0;
            data  <= '0;
        end else if (ld) begin
            entry.full <= 1'b1;
            entry.age  <= age_nxt;
            entry.dest <= ld_dest;
            data       <= ld_data;
        end else if (clr) begin
            entry.full <= 1'b0;
            entry.age  <= 1'b0;
        end else begin
            entry.age  <= age_nxt;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose: arbitrates ALU and memory-unit writebacks onto one register-file
//          write port, with optional read forwarding from the holding buffers.
// Latency: 1 cycle accept-to-write uncontended, 2 cycles when losing arbitration.
// Backpressure: a_ready/m_ready drop while the requester's buffer is full and
//          not granted; one write per cycle sustained.
// Ports: clk, reset (async active-high); a_*/m_* writeback requests;
//        dest/write_enable/data_in register-file write port; src_one/src_two
//        and rf_out_one/rf_out_two read port; out_one/out_two datapath read
//        data; busy = any buffer full.
// Config: define RF_WB_BYPASS_EN to forward buffered data onto out_one/out_two.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    input  logic [REG_IDX_W-1:0] a_dest,
    input  logic [XLEN-1:0]      a_data,
    output logic                 a_ready,
    input  logic                 m_valid,
    input  logic [REG_IDX_W-1:0] m_dest,
    input  logic [XLEN-1:0]      m_data,
    output logic                 m_ready,
    output logic [REG_IDX_W-1:0] dest,
    output logic                 write_enable,
    output logic [XLEN-1:0]      data_in,
    input  logic [REG_IDX_W-1:0] src_one,
    input  logic [REG_IDX_W-1:0] src_two,
    input  logic [XLEN-1:0]      rf_out_one,
    input  logic [XLEN-1:0]      rf_out_two,
    output logic [XLEN-1:0]      out_one,
    output logic [XLEN-1:0]      out_two,
    output logic                 busy
);

    wb_entry_t       a_ent, m_ent;
    logic [XLEN-1:0] a_buf_dat, m_buf_dat;

    req_idx_e gnt_idx;
    logic     wr_vld, gnt_a, gnt_m;
    logic     a_ld, m_ld, a_keep, m_keep;
    logic     a_age_nxt, m_age_nxt;

    // Grant: the MEM buffer wins only when it is the sole full buffer or the
    // ALU buffer is marked younger; ties default to the ALU.
    assign wr_vld  = a_ent.full | m_ent.full;
    assign gnt_idx = (m_ent.full && (!a_ent.full || (a_ent.age && !m_ent.age)))
                     ? REQ_MEM : REQ_ALU;
    assign gnt_a   = wr_vld && (gnt_idx == REQ_ALU);
    assign gnt_m   = wr_vld && (gnt_idx == REQ_MEM);

    // Ready depends only on buffer registers, so no input-to-ready path.
    assign a_ready = !a_ent.full || gnt_a;
    assign m_ready = !m_ent.full || gnt_m;

    assign a_ld   = a_valid && a_ready && !is_zero_reg(a_dest);
    assign m_ld   = m_valid && m_ready && !is_zero_reg(m_dest);
    assign a_keep = a_ent.full && !gnt_a;
    assign m_keep = m_ent.full && !gnt_m;

    // Age tracking: a new entry is younger if the other buffer still holds
    // data after this edge. On a simultaneous load the MEM entry is younger.
    // A surviving entry becomes the elder as soon as the other side drains
    // or is replaced.
    assign a_age_nxt = a_ld ? m_keep : (m_keep & a_ent.age);
    assign m_age_nxt = m_ld ? (a_keep | a_ld) : (a_keep & m_ent.age);

    wb_hold_buf #(.XLEN(XLEN)) u_a_buf (
        .clk     (clk),
        .rst     (reset),
        .ld      (a_ld),
        .clr     (gnt_a),
        .ld_dest (a_dest),
        .ld_data (a_data),
        .age_nxt (a_age_nxt),
        .entry   (a_ent),
        .data    (a_buf_dat)
    );

    wb_hold_buf #(.XLEN(XLEN)) u_m_buf (
        .clk     (clk),
        .rst     (reset),
        .ld      (m_ld),
        .clr     (gnt_m),
        .ld_dest (m_dest),
        .ld_data (m_data),
        .age_nxt (m_age_nxt),
        .entry   (m_ent),
        .data    (m_buf_dat)
    );

    // Write port is a pure mux of buffer registers; idle value is all zero.
    always_comb begin
        write_enable = wr_vld;
        dest         = REG_ZERO;
        data_in      = '0;
        if (gnt_m) begin
            dest    = m_ent.dest;
            data_in = m_buf_dat;
        end else if (gnt_a) begin
            dest    = a_ent.dest;
            data_in = a_buf_dat;
        end
    end

    assign busy = a_ent.full | m_ent.full;

`ifdef RF_WB_BYPASS_EN
    // Forward from a matching full buffer; with two matches the younger
    // buffer holds the value the register will finally contain.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_IDX_W-1:0] src,
        input logic [XLEN-1:0]      rf_val,
        input wb_entry_t            ea,
        input logic [XLEN-1:0]      da,
        input wb_entry_t            em,
        input logic [XLEN-1:0]      dm
    );
        logic hit_a, hit_m;
        hit_a = !is_zero_reg(src) && ea.full && (ea.dest == src);
        hit_m = !is_zero_reg(src) && em.full && (em.dest == src);
        if (hit_a && hit_m) return ea.age ? da : dm;
        if (hit_a)          return da;
        if (hit_m)          return dm;
        return rf_val;
    endfunction

    assign out_one = fwd_sel(src_one, rf_out_one, a_ent, a_buf_dat, m_ent, m_buf_dat);
    assign out_two = fwd_sel(src_two, rf_out_two, a_ent, a_buf_dat, m_ent, m_buf_dat);
`else
    assign out_one = rf_out_one;
    assign out_two = rf_out_two;

    // Read addresses only matter when forwarding is built in.
    logic unused_src;
    assign unused_src = ^{src_one, src_two};
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Purpose: self-checking bench for rf_wb_arbiter against a pending-write queue model.
// Latency: checks outputs mid-cycle, one model step per clock edge.
// Backpressure: model ready = requester has no pending write, or its write is next.
module tb_rf_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            a_valid, m_valid;
    logic [3:0]      a_dest, m_dest;
    logic [XLEN-1:0] a_data, m_data;
    logic            a_ready, m_ready;
    logic [3:0]      dest;
    logic            write_enable;
    logic [XLEN-1:0] data_in;
    logic [3:0]      src_one, src_two;
    logic [XLEN-1:0] rf_out_one, rf_out_two;
    logic [XLEN-1:0] out_one, out_two;
    logic            busy;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_dest       (a_dest),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .m_valid      (m_valid),
        .m_dest       (m_dest),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .dest         (dest),
        .write_enable (write_enable),
        .data_in      (data_in),
        .src_one      (src_one),
        .src_two      (src_two),
        .rf_out_one   (rf_out_one),
        .rf_out_two   (rf_out_two),
        .out_one      (out_one),
        .out_two      (out_two),
        .busy         (busy)
    );

    // Reference model: writes retire in acceptance order, ALU first on a tie.
    typedef struct packed {
        logic            is_m;
        logic [3:0]      dst;
        logic [XLEN-1:0] dat;
    } pend_t;

    pend_t           q[$];
    logic [35:0]     wr_log[$];
    int              n_run = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              first_wr = -1;
    int              last_wr = -1;
    logic            last_acc_a, last_acc_m;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready(input logic is_m);
        for (int i = 0; i < q.size(); i++)
            if (q[i].is_m == is_m) return (i == 0);
        return 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [3:0] src, input logic [XLEN-1:0] rf);
`ifdef RF_WB_BYPASS_EN
        if (src != 4'd0)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].dst == src) return q[i].dat;
`endif
        return rf;
    endfunction

    // One clock: check every output mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic ea, em;
        @(negedge clk);
        ea = model_ready(1'b0);
        em = model_ready(1'b1);
        chk("write_enable", {31'd0, write_enable}, {31'd0, q.size() > 0});
        chk("dest",         {28'd0, dest}, (q.size() > 0) ? {28'd0, q[0].dst} : 32'd0);
        chk("data_in",      data_in, (q.size() > 0) ? q[0].dat : 32'd0);
        chk("busy",         {31'd0, busy}, {31'd0, q.size() > 0});
        chk("a_ready",      {31'd0, a_ready}, {31'd0, ea});
        chk("m_ready",      {31'd0, m_ready}, {31'd0, em});
        chk("out_one",      out_one, model_read(src_one, rf_out_one));
        chk("out_two",      out_two, model_read(src_two, rf_out_two));
        if (write_enable) begin
            wr_log.push_back({dest, data_in});
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        last_acc_a = a_valid && ea;
        last_acc_m = m_valid && em;
        @(posedge clk);
        if (q.size() > 0) void'(q.pop_front());
        if (last_acc_a && a_dest != 4'd0) q.push_back({1'b0, a_dest, a_data});
        if (last_acc_m && m_dest != 4'd0) q.push_back({1'b1, m_dest, m_data});
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_dest = '0; a_data = '0;
        m_valid = 1'b0; m_dest = '0; m_data = '0;
    endtask

    initial begin
        int na, nm, guard;
        logic [XLEN-1:0] exp_rd;
        reset = 1'b1;
        idle_inputs();
        src_one = '0; src_two = '0; rf_out_one = '0; rf_out_two = '0;

        // Reset state
        #1;
        chk("rst_we",    {31'd0, write_enable}, 32'd0);
        chk("rst_dest",  {28'd0, dest}, 32'd0);
        chk("rst_data",  data_in, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ardy",  {31'd0, a_ready}, 32'd1);
        chk("rst_mrdy",  {31'd0, m_ready}, 32'd1);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Single ALU write
        a_valid = 1'b1; a_dest = 4'd5; a_data = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        @(negedge clk);
        chk("single_we",   {31'd0, write_enable}, 32'd1);
        chk("single_dest", {28'd0, dest}, 32'd5);
        chk("single_data", data_in, 32'hDEADBEEF);
        @(posedge clk); #1;
        void'(q.pop_front());
        cycle();
        chk("single_busy_one", {31'd0, busy}, 32'd0);

        // Simultaneous requests to the same register
        wr_log.delete();
        a_valid = 1'b1; a_dest = 4'd3; a_data = 32'h11;
        m_valid = 1'b1; m_dest = 4'd3; m_data = 32'h22;
        cycle();
        chk("simul_m_acc", {31'd0, last_acc_m}, 32'd1);
        idle_inputs();
        repeat (3) cycle();
        chk("simul_cnt", wr_log.size(), 32'd2);
        if (wr_log.size() == 2) begin
            chk("simul_first",  {28'd0, wr_log[0]}, {28'd0, 4'd3, 32'h11});
            chk("simul_second", {28'd0, wr_log[1]}, {28'd0, 4'd3, 32'h22});
        end

        // Back-to-back contention, four requests per side
        wr_log.delete(); first_wr = -1; last_wr = -1;
        na = 0; nm = 0; guard = 0;
        while ((na < 4 || nm < 4) && guard < 20) begin
            a_valid = (na < 4); a_dest = 4'(1 + na); a_data = 32'hA0 + na;
            m_valid = (nm < 4); m_dest = 4'(9 + nm); m_data = 32'hB0 + nm;
            cycle();
            if (last_acc_a) na++;
            if (last_acc_m) nm++;
            guard++;
        end
        chk("b2b_timeout", {31'd0, guard < 20}, 32'd1);
        idle_inputs();
        repeat (3) cycle();
        chk("b2b_cnt",    wr_log.size(), 32'd8);
        chk("b2b_consec", last_wr - first_wr, 32'd7);
        for (int i = 0; i < 8 && i < wr_log.size(); i++)
            chk("b2b_order", {28'd0, wr_log[i][35:32]},
                (i % 2 == 0) ? 32'(1 + i / 2) : 32'(9 + i / 2));

        // Zero register
        a_valid = 1'b1; a_dest = 4'd0; a_data = 32'hFFFF;
        cycle();
        chk("zero_acc", {31'd0, last_acc_a}, 32'd1);
        idle_inputs();
        cycle();
        chk("zero_we",   {31'd0, write_enable}, 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);

        // Read forwarding from the MEM buffer
        m_valid = 1'b1; m_dest = 4'd7; m_data = 32'hCAFE;
        src_one = 4'd7; rf_out_one = 32'h1;
        cycle();
        idle_inputs();
        @(negedge clk);
`ifdef RF_WB_BYPASS_EN
        exp_rd = 32'hCAFE;
`else
        exp_rd = 32'h1;
`endif
        chk("bypass_out_one", out_one, exp_rd);
        @(posedge clk); #1;
        void'(q.pop_front());

        // Reset mid-operation
        a_valid = 1'b1; a_dest = 4'd3; a_data = 32'h33;
        m_valid = 1'b1; m_dest = 4'd4; m_data = 32'h44;
        cycle();
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        chk("midrst_we",   {31'd0, write_enable}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ardy", {31'd0, a_ready}, 32'd1);
        chk("midrst_mrdy", {31'd0, m_ready}, 32'd1);
        q.delete();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        repeat (3) cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            a_valid    = ($urandom_range(0, 3) != 0);
            a_dest     = 4'($urandom_range(0, 7));
            a_data     = $urandom;
            m_valid    = ($urandom_range(0, 3) != 0);
            m_dest     = 4'($urandom_range(0, 7));
            m_data     = $urandom;
            src_one    = 4'($urandom_range(0, 7));
            src_two    = 4'($urandom_range(0, 7));
            rf_out_one = $urandom;
            rf_out_two = $urandom;
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
